// File: rtl/coprocessor_pkg.sv
// Shared constants and types for the coprocessor PIO sequencer:
// register map, CTRL/STATUS bit positions and the sequencer state.
package coprocessor_pkg;

  localparam logic [2:0] ADDR_OPER_LO   = 3'd0;
  localparam logic [2:0] ADDR_OPER_HI   = 3'd1;
  localparam logic [2:0] ADDR_CTRL      = 3'd2;
  localparam logic [2:0] ADDR_RESULT_LO = 3'd3;
  localparam logic [2:0] ADDR_RESULT_HI = 3'd4;
  localparam logic [2:0] ADDR_CYCLES    = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_IRQ_EN  = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } seq_state_t;

endpackage

// File: rtl/coprocessor_pio_sequencer_if.sv
// Avalon-MM slave bus between the Nios II data master and the
// sequencer, including the level interrupt back to the CPU.
interface coprocessor_pio_sequencer_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

endinterface

// File: rtl/coprocessor_timeout_counter.sv
// Saturating cycle counter with clear/enable; flags when the
// incremented value reaches LIMIT (LIMIT of 0 never expires).
module coprocessor_timeout_counter #(
  parameter int W     = 32,
  parameter int LIMIT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         expired
);

  localparam logic [31:0] LIM = LIMIT[31:0];

  logic [31:0] nxt_ext;

  assign count_nxt = (&count) ? count : count + W'(1);
  assign nxt_ext   = 32'(count_nxt);
  assign expired   = (LIM != 32'd0) && (nxt_ext >= LIM);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/coprocessor_pio_sequencer.sv
// Avalon-MM slave that runs one 64-bit operand/result exchange
// with the coprocessor over a 4-phase req/ack handshake.
module coprocessor_pio_sequencer
  import coprocessor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic        clk,
  input  logic        reset,
  coprocessor_pio_sequencer_if.slave bus,
  output logic [31:0] cop_data_lo,
  output logic [31:0] cop_data_hi,
  output logic        cop_req,
  input  logic        cop_ack,
  input  logic [31:0] cop_result_lo,
  input  logic [31:0] cop_result_hi
);

  seq_state_t state, state_n;

  logic [31:0] oper_lo, oper_hi;
  logic [31:0] result_lo, result_hi;
  logic [31:0] result_lo_n, result_hi_n;
  logic [31:0] data_lo_n, data_hi_n;
  logic [CNT_W-1:0] cycles, cycles_n;
  logic done, done_n;
  logic timeout, timeout_n;
  logic irq_en, irq_en_n;
  logic req_n, irq_n;
  logic [31:0] rdata_n;

  logic wr, wr_ctrl, start, clr;
  logic busy;

  logic tmr_clr, tmr_en, tmr_exp;
  logic [CNT_W-1:0] tmr_count, tmr_nxt;

  assign wr      = bus.chipselect && !bus.write_n;
  assign wr_ctrl = wr && (bus.address == ADDR_CTRL);
  assign start   = wr_ctrl && bus.writedata[CTRL_START];
  assign clr     = wr_ctrl && bus.writedata[CTRL_CLR];
  assign busy    = (state != IDLE);

  coprocessor_timeout_counter #(
    .W     (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .count     (tmr_count),
    .count_nxt (tmr_nxt),
    .expired   (tmr_exp)
  );

  always_comb begin
    state_n     = state;
    done_n      = done;
    timeout_n   = timeout;
    irq_en_n    = irq_en;
    cycles_n    = cycles;
    result_lo_n = result_lo;
    result_hi_n = result_hi;
    data_lo_n   = cop_data_lo;
    data_hi_n   = cop_data_hi;
    req_n       = cop_req;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    if (wr_ctrl) irq_en_n = bus.writedata[CTRL_IRQ_EN];
    if (clr) begin
      done_n    = 1'b0;
      timeout_n = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (start) begin
          data_lo_n = oper_lo;
          data_hi_n = oper_hi;
          done_n    = 1'b0;
          timeout_n = 1'b0;
          cycles_n  = '0;
          tmr_clr   = 1'b1;
          req_n     = 1'b1;
          state_n   = REQ;
        end
      end
      REQ: begin
        tmr_en   = 1'b1;
        cycles_n = tmr_nxt;
        // ack beats a coincident expiry
        if (cop_ack) begin
          result_lo_n = cop_result_lo;
          result_hi_n = cop_result_hi;
          req_n       = 1'b0;
          tmr_clr     = 1'b1;
          state_n     = RELEASE;
        end else if (tmr_exp) begin
          req_n     = 1'b0;
          timeout_n = 1'b1;
          tmr_clr   = 1'b1;
          state_n   = RELEASE;
        end
      end
      RELEASE: begin
        tmr_en = 1'b1;
        if (!cop_ack) begin
          done_n  = !timeout_n;
          state_n = IDLE;
        end else if (tmr_exp) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    irq_n = irq_en_n && (done_n || timeout_n);
  end

  always_comb begin
    rdata_n = '0;
    case (bus.address)
      ADDR_OPER_LO:   rdata_n = oper_lo;
      ADDR_OPER_HI:   rdata_n = oper_hi;
      ADDR_CTRL:      rdata_n = {28'd0, irq_en, timeout, done, busy};
      ADDR_RESULT_LO: rdata_n = result_lo;
      ADDR_RESULT_HI: rdata_n = result_hi;
      ADDR_CYCLES:    rdata_n = 32'(cycles);
      default:        rdata_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      oper_lo      <= '0;
      oper_hi      <= '0;
      result_lo    <= '0;
      result_hi    <= '0;
      cycles       <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      irq_en       <= 1'b0;
      cop_data_lo  <= '0;
      cop_data_hi  <= '0;
      cop_req      <= 1'b0;
      bus.irq      <= 1'b0;
      bus.readdata <= '0;
    end else begin
      state        <= state_n;
      result_lo    <= result_lo_n;
      result_hi    <= result_hi_n;
      cycles       <= cycles_n;
      done         <= done_n;
      timeout      <= timeout_n;
      irq_en       <= irq_en_n;
      cop_data_lo  <= data_lo_n;
      cop_data_hi  <= data_hi_n;
      cop_req      <= req_n;
      bus.irq      <= irq_n;
      bus.readdata <= rdata_n;
      if (wr && bus.address == ADDR_OPER_LO) oper_lo <= bus.writedata;
      if (wr && bus.address == ADDR_OPER_HI) oper_hi <= bus.writedata;
    end
  end

endmodule
